// File: rtl/input_conditioner.sv
// input_conditioner
//   Front end between raw board pins and the control logic. Every button and
//   switch bit passes through a 2-FF synchroniser and a counter-based debounce.
//   Buttons additionally get press/release pulses and an optional long-press
//   auto-repeat. Switches get a single "something changed" pulse.
//
// Ports
//   clk_i          system clock
//   rst_ni         synchronous reset, active-low
//   btn_i          raw asynchronous button pins            [N_BTN]
//   sw_i           raw asynchronous switch pins            [SW_W]
//   repeat_en_i    per-button auto-repeat enable           [N_BTN]
//   btn_level_o    debounced button level                  [N_BTN]
//   btn_press_o    1-cycle pulse: press edge and each auto-repeat tick
//   btn_release_o  1-cycle pulse on debounced release
//   sw_o           debounced switch levels                 [SW_W]
//   sw_changed_o   1-cycle pulse when any bit of sw_o changes
module input_conditioner #(
    parameter int unsigned N_BTN         = 5,
    parameter int unsigned SW_W          = 16,
    parameter int unsigned DEBOUNCE_CYC  = 1_000_000,
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_BTN-1:0] btn_i,
    input  logic [SW_W-1:0]  sw_i,
    input  logic [N_BTN-1:0] repeat_en_i,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] btn_press_o,
    output logic [N_BTN-1:0] btn_release_o,
    output logic [SW_W-1:0]  sw_o,
    output logic             sw_changed_o
);

    localparam int unsigned NB   = N_BTN + SW_W;
    localparam int unsigned CW   = $clog2(DEBOUNCE_CYC);
    localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW   = $clog2(TMAX);

    localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_REPEAT,
        S_HOLD
    } state_t;

    // Buttons occupy the low bits, switches the high bits, so one debounce
    // loop serves both.
    logic [NB-1:0]    raw;
    logic [NB-1:0]    s1;
    logic [NB-1:0]    s2;
    logic [NB-1:0]    stable;
    logic [CW-1:0]    cnt [NB];

    logic [N_BTN-1:0] btn_stable;
    logic [SW_W-1:0]  sw_stable;

    state_t           state    [N_BTN];
    state_t           state_nx [N_BTN];
    logic [TW-1:0]    timer    [N_BTN];
    logic [TW-1:0]    timer_nx [N_BTN];
    logic [N_BTN-1:0] press_nx;
    logic [N_BTN-1:0] release_nx;
    logic             rise;
    logic             fall;

    assign raw        = {sw_i, btn_i};
    assign btn_stable = stable[N_BTN-1:0];
    assign sw_stable  = stable[NB-1:N_BTN];

    // Synchroniser and debounce. The counter only runs while s2 disagrees
    // with the accepted level and is cleared on agreement or on acceptance,
    // so it can never wrap.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int unsigned i = 0; i < NB; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= ~stable[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Per-button press/repeat FSM. btn_level_o holds the previous accepted
    // level, so comparing it with the debounce register gives the edge in the
    // same cycle the registered level output is updated.
    always_comb begin
        press_nx   = '0;
        release_nx = '0;
        rise       = 1'b0;
        fall       = 1'b0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            state_nx[i] = state[i];
            timer_nx[i] = timer[i];
            rise        = btn_stable[i] & ~btn_level_o[i];
            fall        = ~btn_stable[i] & btn_level_o[i];
            case (state[i])
                S_IDLE: begin
                    timer_nx[i] = '0;
                    if (rise) begin
                        press_nx[i] = 1'b1;
                        state_nx[i] = repeat_en_i[i] ? S_WAIT : S_HOLD;
                    end
                end
                S_WAIT: begin
                    // Release beats disable, which beats a due tick.
                    if (fall) begin
                        release_nx[i] = 1'b1;
                        state_nx[i]   = S_IDLE;
                        timer_nx[i]   = '0;
                    end else if (!repeat_en_i[i]) begin
                        state_nx[i] = S_HOLD;
                        timer_nx[i] = '0;
                    end else if (timer[i] == DELAY_LAST) begin
                        press_nx[i] = 1'b1;
                        state_nx[i] = S_REPEAT;
                        timer_nx[i] = '0;
                    end else begin
                        timer_nx[i] = timer[i] + TW'(1);
                    end
                end
                S_REPEAT: begin
                    if (fall) begin
                        release_nx[i] = 1'b1;
                        state_nx[i]   = S_IDLE;
                        timer_nx[i]   = '0;
                    end else if (!repeat_en_i[i]) begin
                        state_nx[i] = S_HOLD;
                        timer_nx[i] = '0;
                    end else if (timer[i] == PERIOD_LAST) begin
                        press_nx[i] = 1'b1;
                        timer_nx[i] = '0;
                    end else begin
                        timer_nx[i] = timer[i] + TW'(1);
                    end
                end
                S_HOLD: begin
                    timer_nx[i] = '0;
                    if (fall) begin
                        release_nx[i] = 1'b1;
                        state_nx[i]   = S_IDLE;
                    end
                end
                default: begin
                    state_nx[i] = S_IDLE;
                    timer_nx[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                state[i] <= S_IDLE;
                timer[i] <= '0;
            end
            btn_level_o   <= '0;
            btn_press_o   <= '0;
            btn_release_o <= '0;
            sw_o          <= '0;
            sw_changed_o  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                state[i] <= state_nx[i];
                timer[i] <= timer_nx[i];
            end
            btn_level_o   <= btn_stable;
            btn_press_o   <= press_nx;
            btn_release_o <= release_nx;
            sw_o          <= sw_stable;
            // Bits settling together differ from sw_o in one cycle only,
            // giving a single pulse.
            sw_changed_o  <= (sw_stable != sw_o);
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with short debounce/repeat timings.
// Inputs change 1 ns after a rising edge; "step j" is the j-th edge after
// the change, so the first edge sampling the new pin level is step 1 and
// a debounced change appears at step 7.
module tb_input_conditioner;

    logic        clk;
    logic        rst_n;
    logic [4:0]  btn;
    logic [15:0] sw;
    logic [4:0]  rep;
    logic [4:0]  level;
    logic [4:0]  press;
    logic [4:0]  rel;
    logic [15:0] sw_out;
    logic        sw_chg;

    int nvec;
    int nerr;

    logic [4:0]  el;
    logic [4:0]  ep;
    logic [4:0]  er;
    logic [15:0] es;
    logic        ec;

    input_conditioner #(
        .N_BTN        (5),
        .SW_W         (16),
        .DEBOUNCE_CYC (4),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .btn_i        (btn),
        .sw_i         (sw),
        .repeat_en_i  (rep),
        .btn_level_o  (level),
        .btn_press_o  (press),
        .btn_release_o(rel),
        .sw_o         (sw_out),
        .sw_changed_o (sw_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn   = '0;
        sw    = '0;
        rep   = '0;
        step();
        step();
        nvec++; if (level !== 5'b0) begin $display("FAIL reset_level: got %b expected %b", level, 5'b0); nerr++; end
        nvec++; if (press !== 5'b0) begin $display("FAIL reset_press: got %b expected %b", press, 5'b0); nerr++; end
        nvec++; if (rel !== 5'b0) begin $display("FAIL reset_release: got %b expected %b", rel, 5'b0); nerr++; end
        nvec++; if (sw_out !== 16'h0) begin $display("FAIL reset_sw: got %h expected %h", sw_out, 16'h0); nerr++; end
        nvec++; if (sw_chg !== 1'b0) begin $display("FAIL reset_swchg: got %b expected %b", sw_chg, 1'b0); nerr++; end
        rst_n = 1'b1;
        step();
        nvec++; if (press !== 5'b0) begin $display("FAIL post_reset_press: got %b expected %b", press, 5'b0); nerr++; end
        nvec++; if (rel !== 5'b0) begin $display("FAIL post_reset_release: got %b expected %b", rel, 5'b0); nerr++; end
        nvec++; if (sw_chg !== 1'b0) begin $display("FAIL post_reset_swchg: got %b expected %b", sw_chg, 1'b0); nerr++; end
    endtask

    // Channel 0, no repeat: press at step 7 only, release 7 steps after drop.
    task automatic test_press_release();
        btn[0] = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            step();
            el = (j >= 7) ? 5'b00001 : 5'b00000;
            ep = (j == 7) ? 5'b00001 : 5'b00000;
            nvec++; if (level !== el) begin $display("FAIL pr_level step %0d: got %b expected %b", j, level, el); nerr++; end
            nvec++; if (press !== ep) begin $display("FAIL pr_press step %0d: got %b expected %b", j, press, ep); nerr++; end
            nvec++; if (rel !== 5'b0) begin $display("FAIL pr_release step %0d: got %b expected %b", j, rel, 5'b0); nerr++; end
        end
        btn[0] = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            step();
            el = (j >= 7) ? 5'b00000 : 5'b00001;
            er = (j == 7) ? 5'b00001 : 5'b00000;
            nvec++; if (level !== el) begin $display("FAIL rr_level step %0d: got %b expected %b", j, level, el); nerr++; end
            nvec++; if (press !== 5'b0) begin $display("FAIL rr_press step %0d: got %b expected %b", j, press, 5'b0); nerr++; end
            nvec++; if (rel !== er) begin $display("FAIL rr_release step %0d: got %b expected %b", j, rel, er); nerr++; end
        end
    endtask

    // Channel 1 high for 3 cycles: shorter than the debounce window.
    task automatic test_glitch();
        btn[1] = 1'b1;
        step();
        step();
        step();
        btn[1] = 1'b0;
        for (int j = 4; j <= 14; j++) begin
            step();
            nvec++; if (level !== 5'b0) begin $display("FAIL glitch_level step %0d: got %b expected %b", j, level, 5'b0); nerr++; end
            nvec++; if (press !== 5'b0) begin $display("FAIL glitch_press step %0d: got %b expected %b", j, press, 5'b0); nerr++; end
            nvec++; if (rel !== 5'b0) begin $display("FAIL glitch_release step %0d: got %b expected %b", j, rel, 5'b0); nerr++; end
        end
    endtask

    // Channel 2 with repeat: P=7, ticks at 17, 20; enable dropped after step 21
    // so the tick due at 23 never comes. Release afterwards from HOLD.
    task automatic test_auto_repeat();
        rep[2] = 1'b1;
        btn[2] = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            step();
            ep = (j == 7 || j == 17 || j == 20) ? 5'b00100 : 5'b00000;
            el = (j >= 7) ? 5'b00100 : 5'b00000;
            nvec++; if (press !== ep) begin $display("FAIL rep_press step %0d: got %b expected %b", j, press, ep); nerr++; end
            nvec++; if (level !== el) begin $display("FAIL rep_level step %0d: got %b expected %b", j, level, el); nerr++; end
            nvec++; if (rel !== 5'b0) begin $display("FAIL rep_release step %0d: got %b expected %b", j, rel, 5'b0); nerr++; end
            if (j == 21) rep[2] = 1'b0;
        end
        btn[2] = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            step();
            er = (j == 7) ? 5'b00100 : 5'b00000;
            nvec++; if (rel !== er) begin $display("FAIL rep_rel_release step %0d: got %b expected %b", j, rel, er); nerr++; end
            nvec++; if (press !== 5'b0) begin $display("FAIL rep_rel_press step %0d: got %b expected %b", j, press, 5'b0); nerr++; end
        end
    endtask

    // Channels 3 and 4 together; channel 4 repeats and is released so that
    // its release lands on the tick due at step 20.
    task automatic test_simultaneous();
        rep = 5'b10000;
        btn[3] = 1'b1;
        btn[4] = 1'b1;
        for (int j = 1; j <= 26; j++) begin
            step();
            ep = (j == 7) ? 5'b11000 : ((j == 17) ? 5'b10000 : 5'b00000);
            er = (j == 20) ? 5'b10000 : 5'b00000;
            el = '0;
            if (j >= 7) el[3] = 1'b1;
            if (j >= 7 && j < 20) el[4] = 1'b1;
            nvec++; if (press !== ep) begin $display("FAIL sim_press step %0d: got %b expected %b", j, press, ep); nerr++; end
            nvec++; if (rel !== er) begin $display("FAIL sim_release step %0d: got %b expected %b", j, rel, er); nerr++; end
            nvec++; if (level !== el) begin $display("FAIL sim_level step %0d: got %b expected %b", j, level, el); nerr++; end
            if (j == 13) btn[4] = 1'b0;
        end
        rep = '0;
        btn[3] = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            step();
            er = (j == 7) ? 5'b01000 : 5'b00000;
            nvec++; if (rel !== er) begin $display("FAIL sim_rel3 step %0d: got %b expected %b", j, rel, er); nerr++; end
        end
    endtask

    // All switch bits settle together: one sw_changed pulse per transition.
    task automatic test_switches();
        sw = 16'hA5A5;
        for (int j = 1; j <= 10; j++) begin
            step();
            es = (j >= 7) ? 16'hA5A5 : 16'h0000;
            ec = (j == 7);
            nvec++; if (sw_out !== es) begin $display("FAIL sw_value step %0d: got %h expected %h", j, sw_out, es); nerr++; end
            nvec++; if (sw_chg !== ec) begin $display("FAIL sw_changed step %0d: got %b expected %b", j, sw_chg, ec); nerr++; end
        end
        sw = 16'h0000;
        for (int j = 1; j <= 10; j++) begin
            step();
            es = (j >= 7) ? 16'h0000 : 16'hA5A5;
            ec = (j == 7);
            nvec++; if (sw_out !== es) begin $display("FAIL sw_back_value step %0d: got %h expected %h", j, sw_out, es); nerr++; end
            nvec++; if (sw_chg !== ec) begin $display("FAIL sw_back_changed step %0d: got %b expected %b", j, sw_chg, ec); nerr++; end
        end
    endtask

    // Reset while channel 2 is in REPEAT with the pin (and switches) held.
    task automatic test_reset_mid();
        rep[2] = 1'b1;
        btn[2] = 1'b1;
        sw     = 16'h3C3C;
        for (int j = 1; j <= 20; j++) begin
            step();
            ep = (j == 7 || j == 17 || j == 20) ? 5'b00100 : 5'b00000;
            nvec++; if (press !== ep) begin $display("FAIL mid_pre_press step %0d: got %b expected %b", j, press, ep); nerr++; end
        end
        rst_n = 1'b0;
        step();
        nvec++; if (level !== 5'b0) begin $display("FAIL mid_reset_level: got %b expected %b", level, 5'b0); nerr++; end
        nvec++; if (press !== 5'b0) begin $display("FAIL mid_reset_press: got %b expected %b", press, 5'b0); nerr++; end
        nvec++; if (rel !== 5'b0) begin $display("FAIL mid_reset_release: got %b expected %b", rel, 5'b0); nerr++; end
        nvec++; if (sw_out !== 16'h0) begin $display("FAIL mid_reset_sw: got %h expected %h", sw_out, 16'h0); nerr++; end
        nvec++; if (sw_chg !== 1'b0) begin $display("FAIL mid_reset_swchg: got %b expected %b", sw_chg, 1'b0); nerr++; end
        rst_n = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            step();
            el = (j >= 7) ? 5'b00100 : 5'b00000;
            ep = (j == 7) ? 5'b00100 : 5'b00000;
            es = (j >= 7) ? 16'h3C3C : 16'h0000;
            ec = (j == 7);
            nvec++; if (level !== el) begin $display("FAIL mid_post_level step %0d: got %b expected %b", j, level, el); nerr++; end
            nvec++; if (press !== ep) begin $display("FAIL mid_post_press step %0d: got %b expected %b", j, press, ep); nerr++; end
            nvec++; if (rel !== 5'b0) begin $display("FAIL mid_post_release step %0d: got %b expected %b", j, rel, 5'b0); nerr++; end
            nvec++; if (sw_out !== es) begin $display("FAIL mid_post_sw step %0d: got %h expected %h", j, sw_out, es); nerr++; end
            nvec++; if (sw_chg !== ec) begin $display("FAIL mid_post_swchg step %0d: got %b expected %b", j, sw_chg, ec); nerr++; end
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_press_release();
        test_glitch();
        test_auto_repeat();
        test_simultaneous();
        test_switches();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
